// File: rtl/frame_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_sync                                                 |
// | Description : Frame synchroniser for the "1010" marker detector output.  |
// |               Locks after LOCK_HITS on-time markers, flywheels through   |
// |               misses and drops lock after LOSS_MISSES consecutive misses.|
// |               Optional FRAME_SYNC_STATS_EN adds the slip_cnt output.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module frame_sync #(
    parameter  int FRAME_LEN   = 16,
    parameter  int LOCK_HITS   = 3,
    parameter  int LOSS_MISSES = 2,
    localparam int POS_W       = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             det,
    output logic             locked,
    output logic             frame_start,
    output logic [POS_W-1:0] pos,
    output logic             sync_lost
`ifdef FRAME_SYNC_STATS_EN
    ,
    output logic [15:0]      slip_cnt
`endif
);

    localparam int HIT_W  = $clog2(LOCK_HITS + 1);
    localparam int MISS_W = $clog2(LOSS_MISSES + 1);

    localparam logic [1:0] c_ST_HUNT     = 2'd0;
    localparam logic [1:0] c_ST_VERIFY   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED   = 2'd2;
    localparam logic [1:0] c_ST_FLYWHEEL = 2'd3;

    localparam logic [POS_W-1:0]  c_POS_MAX   = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0]  c_POS_ONE   = POS_W'(1);
    localparam logic [HIT_W-1:0]  c_HIT_ONE   = HIT_W'(1);
    localparam logic [HIT_W-1:0]  c_LOCK_HITS = HIT_W'(LOCK_HITS);
    localparam logic [MISS_W-1:0] c_MISS_ONE  = MISS_W'(1);
    localparam logic [MISS_W-1:0] c_LOSS_MISS = MISS_W'(LOSS_MISSES);

    logic [1:0]        r_state;
    logic [POS_W-1:0]  r_pos;
    logic [HIT_W-1:0]  r_hit_cnt;
    logic [MISS_W-1:0] r_miss_cnt;
    logic              r_sync_lost;

    logic [1:0]        w_state_nxt;
    logic [POS_W-1:0]  w_pos_nxt;
    logic [POS_W-1:0]  w_pos_inc;
    logic [HIT_W-1:0]  w_hit_nxt;
    logic [HIT_W-1:0]  w_hit_inc;
    logic [MISS_W-1:0] w_miss_nxt;
    logic [MISS_W-1:0] w_miss_inc;
    logic              w_sync_lost_nxt;
    logic              w_window;

    assign w_pos_inc  = (r_pos == c_POS_MAX) ? '0 : r_pos + c_POS_ONE;
    assign w_hit_inc  = r_hit_cnt + c_HIT_ONE;
    assign w_miss_inc = r_miss_cnt + c_MISS_ONE;
    assign w_window   = (r_state != c_ST_HUNT) && (r_pos == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_ST_HUNT;
            r_pos       <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_hit_cnt   <= w_hit_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_sync_lost <= w_sync_lost_nxt;
        end
    end

    // det is only acted on in HUNT or in a window cycle; anything else is noise.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = (r_state == c_ST_HUNT) ? '0 : w_pos_inc;
        w_hit_nxt       = r_hit_cnt;
        w_miss_nxt      = r_miss_cnt;
        w_sync_lost_nxt = 1'b0;

        case (r_state)
            c_ST_HUNT: begin
                if (det) begin
                    w_pos_nxt   = c_POS_ONE;
                    w_hit_nxt   = c_HIT_ONE;
                    w_miss_nxt  = '0;
                    w_state_nxt = (LOCK_HITS == 1) ? c_ST_LOCKED : c_ST_VERIFY;
                end
            end
            c_ST_VERIFY: begin
                if (w_window) begin
                    if (det) begin
                        w_hit_nxt = w_hit_inc;
                        if (w_hit_inc == c_LOCK_HITS) begin
                            w_state_nxt = c_ST_LOCKED;
                        end
                    end else begin
                        w_state_nxt = c_ST_HUNT;
                        w_pos_nxt   = '0;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_window && !det) begin
                    if (LOSS_MISSES == 1) begin
                        w_state_nxt     = c_ST_HUNT;
                        w_pos_nxt       = '0;
                        w_miss_nxt      = '0;
                        w_sync_lost_nxt = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_FLYWHEEL;
                        w_miss_nxt  = c_MISS_ONE;
                    end
                end
            end
            default: begin
                if (w_window) begin
                    if (det) begin
                        w_state_nxt = c_ST_LOCKED;
                        w_miss_nxt  = '0;
                    end else if (w_miss_inc == c_LOSS_MISS) begin
                        w_state_nxt     = c_ST_HUNT;
                        w_pos_nxt       = '0;
                        w_miss_nxt      = '0;
                        w_sync_lost_nxt = 1'b1;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
            end
        endcase
    end

    assign locked      = (r_state == c_ST_LOCKED) || (r_state == c_ST_FLYWHEEL);
    assign frame_start = locked && (r_pos == '0);
    assign pos         = r_pos;
    assign sync_lost   = r_sync_lost;

`ifdef FRAME_SYNC_STATS_EN
    logic [15:0] r_slip_cnt;

    // Counted on the same edge that raises sync_lost, saturating.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_slip_cnt <= '0;
        end else if (w_sync_lost_nxt && (r_slip_cnt != 16'hFFFF)) begin
            r_slip_cnt <= r_slip_cnt + 16'd1;
        end
    end

    assign slip_cnt = r_slip_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_frame_sync                                              |
// | Description : Scoreboard bench for frame_sync against a marker-timing    |
// |               reference model (FRAME_SYNC_STATS_EN aware).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_frame_sync;

    localparam int F  = 16;
    localparam int LH = 3;
    localparam int LM = 2;

    logic       clk;
    logic       resetn;
    logic       det;
    logic       locked;
    logic       frame_start;
    logic [3:0] pos;
    logic       sync_lost;
`ifdef FRAME_SYNC_STATS_EN
    logic [15:0] slip_cnt;
`endif

    frame_sync #(.FRAME_LEN(F), .LOCK_HITS(LH), .LOSS_MISSES(LM)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .det         (det),
        .locked      (locked),
        .frame_start (frame_start),
        .pos         (pos),
        .sync_lost   (sync_lost)
`ifdef FRAME_SYNC_STATS_EN
        ,
        .slip_cnt    (slip_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit locked;
        bit fs;
        bit lost;
        int pos;
        int slip;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: an anchor time marks the first accepted marker, and
    // windows are simply every F cycles after it.
    int m_n      = 0;
    int m_anchor = 0;
    bit m_hunt   = 1;
    bit m_lock   = 0;
    int m_hits   = 0;
    int m_miss   = 0;
    int m_slip   = 0;

    task automatic model_reset();
        m_hunt = 1; m_lock = 0; m_hits = 0; m_miss = 0; m_slip = 0;
    endtask

    task automatic model_step(input bit d, output exp_t e);
        bit lost;
        lost = 0;
        if (m_hunt) begin
            if (d) begin
                m_anchor = m_n; m_hits = 1; m_miss = 0;
                m_hunt = 0; m_lock = (LH == 1);
            end
        end else if (((m_n - m_anchor) % F) == 0) begin
            if (!m_lock) begin
                if (d) begin
                    m_hits++;
                    if (m_hits == LH) m_lock = 1;
                end else begin
                    m_hunt = 1;
                end
            end else if (d) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == LM) begin
                    m_hunt = 1; m_lock = 0; lost = 1;
                end
            end
        end
        if (lost && m_slip < 65535) m_slip++;
        e.locked = !m_hunt && m_lock;
        e.pos    = m_hunt ? 0 : ((m_n + 1 - m_anchor) % F);
        e.fs     = e.locked && (e.pos == 0);
        e.lost   = lost;
        e.slip   = m_slip;
        m_n++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus: drive det on the falling edge and queue the expected result.
    task automatic cycle(input bit d);
        exp_t e;
        @(negedge clk);
        det = d;
        model_step(d, e);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        resetn = 1'b0;
        det    = 1'b0;
        #1;
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_frame_start", {31'd0, frame_start}, 0);
        chk("rst_sync_lost", {31'd0, sync_lost}, 0);
        chk("rst_pos", {28'd0, pos}, 0);
`ifdef FRAME_SYNC_STATS_EN
        chk("rst_slip_cnt", {16'd0, slip_cnt}, 0);
`endif
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Markers at first + k*F for each set bit k of keep; optional spurious
    // pulse at offset spur within each frame.
    task automatic play(input int ncyc, input int first, input logic [15:0] keep, input int spur);
        for (int i = 0; i < ncyc; i++) begin
            bit d;
            int rel;
            d   = 0;
            rel = i - first;
            if (rel >= 0) begin
                if ((rel % F) == 0 && (rel / F) < 16 && keep[rel / F]) d = 1;
                if (spur > 0 && (rel % F) == spur) d = 1;
            end
            cycle(d);
        end
    endtask

    // Monitor: compare each DUT output against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("locked", {31'd0, locked}, {31'd0, e.locked});
                chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
                chk("sync_lost", {31'd0, sync_lost}, {31'd0, e.lost});
                chk("pos", {28'd0, pos}, e.pos);
`ifdef FRAME_SYNC_STATS_EN
                chk("slip_cnt", {16'd0, slip_cnt}, e.slip);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drop_t[6]  = '{0, 10, 30, 60, 5, 20};
        int noise_t[6] = '{0, 2, 5, 1, 10, 3};
        resetn = 1'b1;
        det    = 1'b0;

        // Acquisition and steady lock.
        do_reset();
        play(120, 5, 16'hFFFF, 0);
        // Verification failure on the third marker.
        do_reset();
        play(80, 5, 16'h0003, 0);
        // One missed marker, flywheeled.
        do_reset();
        play(120, 5, 16'hFFF7, 0);
        // Two missed markers, lock lost, then re-acquire.
        do_reset();
        play(200, 5, 16'hFFE7, 0);
        // Spurious pulses at pos 7 while locked, then mid-frame reset.
        do_reset();
        play(100, 5, 16'hFFFF, 7);
        do_reset();
        play(80, 3, 16'hFFFF, 0);

        // Randomized marker streams with drops and noise.
        for (int b = 0; b < 6; b++) begin
            int phase;
            phase = $urandom_range(0, F - 1);
            for (int t = 0; t < 500; t++) begin
                bit d;
                d = (((t % F) == phase) && ($urandom_range(0, 99) >= drop_t[b]))
                    || ($urandom_range(0, 99) < noise_t[b]);
                cycle(d);
                if (b == 3 && t == 250) do_reset();
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
